// File: rtl/potential_decay_array.sv
// potential_decay_array: per-neuron FP32 potential store with a timestep decay sweep
module potential_decay_array #(
  parameter int         NUM_NEURONS  = 16,
  parameter int         ADDR_W       = 4,
  parameter logic [3:0] DEFAULT_RATE = 4'b0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [31:0]       cfg_potential,
  input  logic [3:0]        cfg_rate,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [31:0]       upd_potential,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_potential,
  output logic [ADDR_W:0]   flush_cnt,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_potential
);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t            r_state, w_next;
  logic [31:0]       r_pot [NUM_NEURONS];
  logic [3:0]        r_rate [NUM_NEURONS];
  logic [ADDR_W-1:0] r_idx, r_out_addr;
  logic [31:0]       r_out_pot, r_rd;
  logic [ADDR_W:0]   r_flush;
  logic              r_out_valid, r_done;
  logic              w_busy, w_last, w_cfg_ok, w_upd_ok, w_rd_ok;
  logic [32:0]       w_dec;

  // Returns {flushed, decayed value}; multiply mode keeps 7 guard bits below the mantissa
  function automatic logic [32:0] decay(input logic [31:0] p, input logic [3:0] r);
    logic [7:0]  e;
    logic [30:0] x, d;
    logic [31:0] z;
    e = p[30:23];
    z = {p[31], 31'h0};
    x = {1'b1, p[22:0], 7'h0};
    d = x - (x >> r[2:0]);
    if (!d[30]) begin
      d = d << 1;
      e = e - 8'd1;
    end
    if (r == 4'b1000) return 33'h0;
    if (p[30:23] == 8'hff) return {1'b0, p};
    if (p[30:23] == 8'h00) return {1'b0, z};
    if (!r[3]) return (p[30:23] <= {5'h0, r[2:0]}) ? {1'b1, z} : {1'b0, p[31], p[30:23] - {5'h0, r[2:0]}, p[22:0]};
    return (e == 8'h00) ? {1'b1, z} : {1'b0, p[31], e, d[29:7]};
  endfunction

  assign w_busy        = r_state == SWEEP;
  assign w_last        = r_idx == ADDR_W'(NUM_NEURONS - 1);
  assign w_cfg_ok      = 32'(cfg_addr) < NUM_NEURONS;
  assign w_upd_ok      = 32'(upd_addr) < NUM_NEURONS;
  assign w_rd_ok       = 32'(rd_addr) < NUM_NEURONS;
  assign w_dec         = decay(r_pot[r_idx], r_rate[r_idx]);
  assign busy          = w_busy;
  assign upd_ready     = !w_busy;
  assign done          = r_done;
  assign out_valid     = r_out_valid;
  assign out_addr      = r_out_addr;
  assign out_potential = r_out_pot;
  assign flush_cnt     = r_flush;
  assign rd_potential  = r_rd;

  // State register
  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_next;

  // Next state: start launches a sweep, the last index ends it
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && start) ? SWEEP : (w_busy && w_last) ? IDLE : r_state;
  end

  // Potential/rate memory: sweep write-back when busy, otherwise upd then cfg so cfg wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        r_pot[i]  <= '0;
        r_rate[i] <= DEFAULT_RATE;
      end
    end else if (w_busy) begin
      r_pot[r_idx] <= w_dec[31:0];
    end else begin
      if (upd_valid && w_upd_ok) r_pot[upd_addr] <= upd_potential;
      if (cfg_we && w_cfg_ok) begin
        r_pot[cfg_addr]  <= cfg_potential;
        r_rate[cfg_addr] <= cfg_rate;
      end
    end
  end

  // Sweep index, result stream, done pulse, flush counter and read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_pot   <= '0;
      r_done      <= 1'b0;
      r_flush     <= '0;
      r_rd        <= '0;
    end else begin
      r_idx       <= (w_busy && !w_last) ? r_idx + 1'b1 : '0;
      r_out_valid <= w_busy;
      r_out_addr  <= w_busy ? r_idx : r_out_addr;
      r_out_pot   <= w_busy ? w_dec[31:0] : r_out_pot;
      r_done      <= w_busy && w_last;
      r_flush     <= (!w_busy && start) ? '0 : r_flush + (ADDR_W+1)'(w_busy & w_dec[32]);
      r_rd        <= w_rd_ok ? r_pot[rd_addr] : '0;
    end
  end
endmodule

// File: tb/tb_potential_decay_array.sv
// tb_potential_decay_array: vector table, corner sequences and random sweeps against a float-rule model
module tb_potential_decay_array;
  localparam int NN = 12;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [31:0]   cfg_potential = '0;
  logic [3:0]    cfg_rate = '0;
  logic          upd_valid = 1'b0;
  logic          upd_ready;
  logic [AW-1:0] upd_addr = '0;
  logic [31:0]   upd_potential = '0;
  logic          start = 1'b0;
  logic          busy, done, out_valid;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_potential;
  logic [AW:0]   flush_cnt;
  logic [AW-1:0] rd_addr = '0;
  logic [31:0]   rd_potential;

  always #5 clk = ~clk;

  potential_decay_array #(.NUM_NEURONS(NN), .ADDR_W(AW), .DEFAULT_RATE(4'b0001)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_potential(cfg_potential), .cfg_rate(cfg_rate), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_potential(upd_potential),
    .start(start), .busy(busy), .done(done), .out_valid(out_valid),
    .out_addr(out_addr), .out_potential(out_potential), .flush_cnt(flush_cnt),
    .rd_addr(rd_addr), .rd_potential(rd_potential)
  );

  typedef struct {
    logic [31:0] pot;
    logic [3:0]  rate;
    logic [31:0] exp;
    int          fl;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pot [NN];
  logic [3:0]  m_rate [NN];
  logic [31:0] last_out [NN];
  vec_t        vecs [9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Decay from the float rules: value * 2^-k, or mantissa * (2^k-1) / 2^k truncated
  function automatic logic [32:0] ref_decay(input logic [31:0] p, input logic [3:0] r);
    int          e;
    int          k;
    longint      v;
    logic [31:0] z;
    e = int'(p[30:23]);
    k = int'(r[2:0]);
    z = {p[31], 31'h0};
    if (r == 4'b1000) return 33'h0;
    if (e == 255) return {1'b0, p};
    if (e == 0) return {1'b0, z};
    if (!r[3]) return (e <= k) ? {1'b1, z} : {1'b0, p[31], 8'(e - k), p[22:0]};
    v = longint'({1'b1, p[22:0]}) * ((longint'(1) << k) - 1);
    if (v < (longint'(1) << (23 + k))) begin
      e--;
      v = v >> (k - 1);
    end else begin
      v = v >> k;
    end
    return (e == 0) ? {1'b1, z} : {1'b0, p[31], 8'(e), v[22:0]};
  endfunction

  function automatic logic [31:0] rnd_pot();
    int          s;
    logic [31:0] p;
    s = int'($urandom_range(0, 5));
    p = $urandom;
    if (s == 0) p[30:23] = 8'h00;
    else if (s == 1) p[30:23] = 8'hff;
    else if (s == 2) p[30:23] = 8'($urandom_range(1, 8));
    return p;
  endfunction

  task automatic reset_model;
    for (int i = 0; i < NN; i++) begin
      m_pot[i]  = '0;
      m_rate[i] = 4'b0001;
    end
  endtask

  task automatic cfg_write(input int a, input logic [31:0] p, input logic [3:0] r);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_potential = p;
    cfg_rate = r;
    tick;
    cfg_we = 1'b0;
    if (a < NN) begin
      m_pot[a]  = p;
      m_rate[a] = r;
    end
  endtask

  task automatic upd_write(input int a, input logic [31:0] p);
    upd_valid = 1'b1;
    upd_addr = AW'(a);
    upd_potential = p;
    tick;
    upd_valid = 1'b0;
    if (a < NN) m_pot[a] = p;
  endtask

  task automatic rd_check(input int a);
    logic [31:0] e;
    e = 32'h0;
    if (a < NN) e = m_pot[a];
    rd_addr = AW'(a);
    tick;
    check("rd_potential", 64'(rd_potential), 64'(e));
  endtask

  // One full sweep; cycles lo..hi inject start/cfg/upd while busy, which must be ignored
  task automatic run_sweep(input int lo, input int hi);
    int          fl;
    logic [32:0] r;
    fl = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    cfg_we = 1'b0;
    upd_valid = 1'b0;
    check("start_edge", 64'({busy, done, out_valid, flush_cnt}), 64'({3'b100, 5'd0}));
    for (int c = 1; c <= NN; c++) begin
      if (c >= lo && c <= hi) begin
        start = 1'b1;
        cfg_we = 1'b1;
        upd_valid = 1'b1;
        cfg_addr = AW'($urandom_range(0, NN - 1));
        upd_addr = AW'($urandom_range(0, NN - 1));
        cfg_potential = $urandom;
        upd_potential = $urandom;
        cfg_rate = 4'($urandom);
        check("upd_ready_busy", 64'(upd_ready), 64'(0));
      end
      tick;
      start = 1'b0;
      cfg_we = 1'b0;
      upd_valid = 1'b0;
      check("sweep_ctl", 64'({out_valid, out_addr, busy, done}), 64'({1'b1, AW'(c - 1), c < NN, c == NN}));
      r = ref_decay(m_pot[c-1], m_rate[c-1]);
      check("sweep_pot", 64'(out_potential), 64'(r[31:0]));
      last_out[c-1] = out_potential;
      m_pot[c-1] = r[31:0];
      fl += int'(r[32]);
    end
    check("flush_cnt", 64'(flush_cnt), 64'(fl));
    tick;
    check("after_done", 64'({busy, done, out_valid, flush_cnt}), 64'({3'b000, 5'(fl)}));
  endtask

  initial begin
    vecs[0] = '{32'h41DEB852, 4'b0001, 32'h415EB852, 0};
    vecs[1] = '{32'h41DEB852, 4'b1010, 32'h41A70A3D, 0};
    vecs[2] = '{32'h3F800000, 4'b1001, 32'h3F000000, 0};
    vecs[3] = '{32'h00800000, 4'b0001, 32'h00000000, 1};
    vecs[4] = '{32'hC0000000, 4'b0011, 32'hBE800000, 0};
    vecs[5] = '{32'h7F800000, 4'b0001, 32'h7F800000, 0};
    vecs[6] = '{32'hC1200000, 4'b1000, 32'h00000000, 0};
    vecs[7] = '{32'h80000001, 4'b0001, 32'h80000000, 0};
    vecs[8] = '{32'h80800000, 4'b1001, 32'h80000000, 1};
    reset_model();

    tick;
    tick;
    check("reset_ctl", 64'({busy, done, out_valid, out_addr, flush_cnt, upd_ready}), 64'({3'b000, 4'h0, 5'd0, 1'b1}));
    check("reset_out", 64'({out_potential, rd_potential}), 64'(0));
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 9; i++) begin
      cfg_write(0, vecs[i].pot, vecs[i].rate);
      run_sweep(1, 0);
      check("vec_out", 64'(last_out[0]), 64'(vecs[i].exp));
      check("vec_flush", 64'(flush_cnt), 64'(vecs[i].fl));
    end

    cfg_we = 1'b1;
    cfg_addr = 4'd2;
    cfg_potential = 32'h3F800000;
    cfg_rate = 4'b0010;
    upd_valid = 1'b1;
    upd_addr = 4'd2;
    upd_potential = 32'h40000000;
    tick;
    cfg_we = 1'b0;
    upd_valid = 1'b0;
    m_pot[2] = 32'h3F800000;
    m_rate[2] = 4'b0010;
    rd_addr = 4'd2;
    tick;
    check("cfg_wins", 64'(rd_potential), 64'(32'h3F800000));

    cfg_write(13, 32'h40400000, 4'b0001);
    upd_write(12, 32'h40400000);
    rd_check(13);
    rd_check(12);

    cfg_write(3, 32'h3F800000, 4'b0001);
    upd_valid = 1'b1;
    upd_addr = 4'd3;
    upd_potential = 32'h40400000;
    m_pot[3] = 32'h40400000;
    run_sweep(1, 0);
    check("upd_at_start", 64'(last_out[3]), 64'(32'h3FC00000));

    run_sweep(4, 8);
    run_sweep(1, 0);

    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    rst_n = 1'b0;
    rd_addr = 4'd3;
    tick;
    check("abort_ctl", 64'({busy, done, out_valid, flush_cnt}), 64'(0));
    check("abort_rd", 64'({out_potential, rd_potential}), 64'(0));
    rst_n = 1'b1;
    reset_model();
    for (int a = 0; a < NN; a++) begin
      rd_check(a);
      check("abort_no_done", 64'({done, busy}), 64'(0));
    end

    for (int n = 0; n < 6; n++) begin
      for (int j = 0; j < 10; j++) begin
        int a;
        a = int'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) cfg_write(a, rnd_pot(), 4'($urandom));
        else upd_write(a, rnd_pot());
      end
      for (int j = 0; j < 3; j++) rd_check(int'($urandom_range(0, 15)));
      run_sweep(1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
